uart_boot_ctrl: RTL

UART_BOOT_CTRL -- requirements
Module: uart_boot_ctrl

---
 rtl/uart_boot_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl: assembles little-endian 32-bit words from a UART byte
// stream and writes them into instruction memory, then data memory, while
// holding the CPU in reset. An idle timeout ends a short image early.
// Optional build macro BOOT_CHECKSUM_EN: a trailing checksum word is
// compared against the wrap-around sum of every written word.
module uart_boot_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int NUM_IWORDS  = 16384,
  parameter int NUM_DWORDS  = 16384,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              cpuclk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              uart_done,
  output logic              cpu_rst_n,
  output logic              boot_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;      // bytes already held in word_q
  logic [23:0]         word_q, word_d;    // low three bytes of the word in flight
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                flush_q, flush_d;  // current WRITE is a timeout flush
  logic                sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                crst_q, crst_d;
  logic                err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]         sum_q, sum_d;
`endif

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      idle_q  <= '0;
      flush_q <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      crst_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      idle_q  <= idle_d;
      flush_q <= flush_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      crst_q  <= crst_d;
      err_q   <= err_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next-state logic: byte assembly, write sequencing, idle timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    idle_d  = idle_q;
    flush_d = flush_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    // CPU is released the cycle after done, and never on an image error
    crst_d  = done_q & ~err_q;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          word_d  = {16'h0, rx_data};
          cnt_d   = 2'd1;
          idle_d  = '0;
          state_d = RECV;
        end
      end

      RECV, CHECK: begin
        if (rx_valid) begin
          idle_d = '0;
          if (cnt_q == 2'd3) begin
            cnt_d  = '0;
            word_d = '0;
            if (state_q == RECV) begin
              wdata_d = {rx_data, word_q};
              state_d = WRITE;
            end
`ifdef BOOT_CHECKSUM_EN
            else begin
              err_d   = ({rx_data, word_q} != sum_q);
              done_d  = 1'b1;
              state_d = DONE;
            end
`endif
          end else begin
            unique case (cnt_q)
              2'd0:    word_d[7:0]   = rx_data;
              2'd1:    word_d[15:8]  = rx_data;
              default: word_d[23:16] = rx_data;
            endcase
            cnt_d = cnt_q + 2'd1;
          end
        end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
          // Timeout: flush a partial word (upper bytes already zero)
          cnt_d  = '0;
          word_d = '0;
`ifdef BOOT_CHECKSUM_EN
          // the checksum never arrived, so the image cannot be trusted
          err_d  = 1'b1;
`endif
          if (state_q == RECV && cnt_q != 2'd0) begin
            wdata_d = {8'h0, word_q};
            flush_d = 1'b1;
            state_d = WRITE;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      WRITE: begin
`ifdef BOOT_CHECKSUM_EN
        sum_d = sum_q + wdata_q;
`endif
        if (!sel_q && addr_q == ADDR_W'(NUM_IWORDS - 1)) begin
          sel_d  = 1'b1;
          addr_d = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
        // A byte arriving during the write starts the next word
        if (rx_valid) begin
          word_d = {16'h0, rx_data};
          cnt_d  = 2'd1;
          idle_d = '0;
        end
        if (flush_q) begin
          flush_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (sel_q && addr_q == ADDR_W'(NUM_DWORDS - 1)) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = CHECK;
`else
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end

      default: ; // DONE: terminal, bytes ignored
    endcase
  end

  assign mem_we    = (state_q == WRITE);
  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign uart_done = done_q;
  assign cpu_rst_n = crst_q;
  assign boot_err  = err_q;

endmodule
